// File: rtl/input_ctrl_ar.sv
// input_ctrl_ar: button decoder with per-button auto-repeat strobes, conflict detection and mode select
module input_ctrl_ar #(
  parameter int               N_BTN        = 5,
  parameter int               MAX_ACTIVE   = 1,
  parameter int               REPEAT_DELAY = 30,
  parameter int               REPEAT_RATE  = 8,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = 5'b00011,
  parameter logic [N_BTN-1:0] MOVE_MASK    = 5'b00011,
  parameter logic [N_BTN-1:0] AIM_MASK     = 5'b01100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn,
  input  logic             start_new_game,
  output logic [N_BTN-1:0] pulse,
  output logic [4:0]       select,
  output logic             conflict
);
  localparam int MX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam int PW = $clog2(N_BTN + 1);
  localparam logic [CW-1:0] D_END = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] R_END = CW'(REPEAT_RATE - 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  logic [PW-1:0]    w_cnt;
  logic             w_valid;
  logic [4:0]       w_sel_nxt;
  logic [N_BTN-1:0] r_prev;
  logic             r_sng_d;
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < N_BTN; k++) w_cnt = w_cnt + PW'(btn[k]);
  end
  assign w_valid   = 32'(w_cnt) <= MAX_ACTIVE;
  assign w_sel_nxt = !w_valid                   ? 5'b00000 :
                     r_sng_d                    ? 5'b00100 :
                     start_new_game             ? 5'b00010 :
                     (btn & MOVE_MASK) != '0    ? 5'b10000 :
                     (btn & AIM_MASK)  != '0    ? 5'b01000 : 5'b00000;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_prev   <= '0;
      r_sng_d  <= 1'b0;
      select   <= '0;
      conflict <= 1'b0;
    end else if (ena) begin
      r_prev   <= btn;
      r_sng_d  <= start_new_game;
      select   <= w_sel_nxt;
      conflict <= !w_valid;
    end
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t        r_st;
    logic [CW-1:0] r_cnt;
    logic          r_pls;
    assign pulse[i] = r_pls;
    // strobe self-clears every clk so it is one clk wide even when ena is sparse
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r_st  <= IDLE;
        r_cnt <= '0;
        r_pls <= 1'b0;
      end else begin
        r_pls <= 1'b0;
        if (ena) begin
          if (!w_valid) begin
            r_st  <= IDLE;
            r_cnt <= '0;
          end else case (r_st)
            IDLE: if (btn[i] && !r_prev[i]) begin
              r_pls <= 1'b1;
              r_cnt <= '0;
              r_st  <= DELAY;
            end
            DELAY: if (!btn[i]) begin
              r_st  <= IDLE;
              r_cnt <= '0;
            end else if (REPEAT_MASK[i] && r_cnt == D_END) begin
              r_pls <= 1'b1;
              r_cnt <= '0;
              r_st  <= REPEAT;
            end else if (r_cnt != D_END) r_cnt <= r_cnt + 1'b1;
            REPEAT: if (!btn[i]) begin
              r_st  <= IDLE;
              r_cnt <= '0;
            end else if (r_cnt == R_END) begin
              r_pls <= 1'b1;
              r_cnt <= '0;
            end else r_cnt <= r_cnt + 1'b1;
            default: begin
              r_st  <= IDLE;
              r_cnt <= '0;
            end
          endcase
        end
      end
  end
endmodule
